smg_scan_multi: RTL and testbench
=================================

// Module: smg_scan_multi
// PURPOSE
//  Parametrised multiplexed seven-segment scan driver for N_DIG digits; generalises the two-digit row/column scan.
//  Decodes per-digit hex nibbles to segments, time-multiplexes digit selects, and adds ghost-suppression dead time.
//  Also adds PWM brightness, per-digit decimal point, leading-zero blanking and tear-free frame snapshotting.
//  Sits between display-value logic (counters, BCD converters) and the board segment/digit pins.
// PARAMETERS
//  N_DIG        4      number of digits, 2..8; digit 0 = least significant, rightmost
//  SCAN_CNT     50000  CLK cycles per digit slot, >= DEAD_CNT+2
//  DEAD_CNT     500    cycles at start of each slot with all digits off (anti-ghosting)
//  BR_W         4      brightness word width; PWM period = 2**BR_W cycles
//  LZB_EN       1      1 = blank leading zeros (digit 0 never blanked)
//  SEG_ACT_LOW  1      1 = segment outputs active-low (common anode)
//  COL_ACT_LOW  1      1 = digit-select outputs active-low
// PORTS
//  CLK           in   1          system clock
//  RSTn          in   1          asynchronous active-low reset
//  Enable        in   1          1 = scanning; 0 = display dark, scan restarts at digit 0
//  Digit_Data    in   4*N_DIG    hex nibble per digit; [3:0] = digit 0
//  Dp_Mask       in   N_DIG      1 = light decimal point of that digit
//  Blank_Mask    in   N_DIG      1 = force that digit blank
//  Brightness    in   BR_W       duty: on when pwm_cnt < Brightness; 0 = dark
//  Row_Scan_Sig  out  8          segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  Col_Scan_Sig  out  N_DIG      one-hot digit select, polarity per COL_ACT_LOW
//  Frame_Sync    out  1          1-cycle pulse when digit-0 slot begins (snapshot taken)
// BEHAVIOUR
//  - Reset (RSTn=0, async): slot_cnt=0, dig_idx=0, pwm_cnt=0, snapshot regs=0; all outputs inactive
//    (segments/selects at inactive polarity), Frame_Sync=0. Same state held while Enable=0.
//  - slot_cnt counts 0..SCAN_CNT-1; on wrap dig_idx increments, N_DIG-1 -> 0 wraps.
//  - Snapshot: at cycle with slot_cnt==0 and dig_idx==0, Digit_Data/Dp_Mask/Blank_Mask latched;
//    input changes mid-frame never appear until the next frame. Frame_Sync asserted the same cycle.
//  - First frame after reset/Enable rise: snapshot taken in cycle 0 of enabled operation.
//  - pwm_cnt free-runs mod 2**BR_W while Enable=1, independent of slot_cnt.
//  - Digit active iff Enable & slot_cnt>=DEAD_CNT & pwm_cnt<Brightness & !blank(dig_idx).
//  - blank(i) = Blank_Mask_s[i] | lz(i); lz(i)=LZB_EN & i!=0 & nibble_s[j]==0 for all j>=i.
//    Dp of a leading-zero digit does not override blanking; Blank_Mask also suppresses dp.
//  - Active digit: Col_Scan_Sig one-hot at dig_idx, segments = decode(nibble_s[dig_idx]) | dp<<7.
//    Inactive: all selects and segments inactive (both, never segment-only).
//  - Decode (active-high, before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  - Latency: all outputs registered; pins reflect internal state 1 cycle later. Frame_Sync also registered.
//  - Enable falling mid-slot: outputs inactive next cycle; counters cleared.
//  - Brightness change applies immediately (not snapshotted); brightness = 2**BR_W-1 gives 15/16 on (BR_W=4).
// STRUCTURE
//  - Shared package smg_pkg: 7-seg encoding constants (SEG_0..SEG_F), bit-order localparams, function
//    to apply polarity.
//  - One sub-module: smg_hex_decoder (4-bit nibble -> 7-bit active-high segments, combinational).
//  - Top: slot/digit counters, pwm counter, snapshot regs, LZ-blank logic, output regs.
// TESTING  (N_DIG=4, SCAN_CNT=8, DEAD_CNT=2, BR_W=4, LZB_EN=1, active-low both)
//  - Reset: RSTn=0 mid-slot -> Row=8'hFF, Col=4'hF immediately; after release scan begins at digit 0.
//  - Digit_Data=16'h1234, Brightness=15, masks 0 -> digit0 slot cycles 2..7 Col=4'b1110, Row=~8'h66
//    (except pwm off cycle); cycles 0..1 all off; digit3 shows ~8'h06.
//  - Digit_Data=16'h0050, Dp_Mask=4'b0010 -> digits 3,2 blank; digit1 Row=~8'hED; digit0 Row=~8'h3F.
//  - Digit_Data changed 16'h1111->16'h2222 during digit1 slot -> digit2/3 still show 1; 2 shown from
//    next Frame_Sync.
//  - Brightness=0 -> Col stays 4'hF for full frame; Brightness=8 -> each active digit on 8 of 16 pwm cycles.
//  - Enable dropped in digit2 slot -> outputs inactive next cycle; re-enable -> Frame_Sync, scan at digit 0.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
package smg_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Bit positions within the 8-bit segment bus {dp,g,f,e,d,c,b,a}
    localparam int SEG_BUS_W  = 8;
    localparam int SEG_DP_BIT = 7;
    localparam int SEG_A_BIT  = 0;

    // Convert an active-high segment bus to pin polarity
    function automatic logic [SEG_BUS_W-1:0] apply_pol(input logic [SEG_BUS_W-1:0] v,
                                                        input logic act_low);
        return act_low ? ~v : v;
    endfunction

endpackage

// File: rtl/smg_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module smg_hex_decoder
    import smg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Nibble lookup into the shared segment table
    always_comb begin
        o_seg = SEG_0;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/smg_scan_multi.sv
// Multiplexed N-digit seven-segment scan driver with dead time, PWM dimming,
// leading-zero blanking and per-frame input snapshot.
module smg_scan_multi
    import smg_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter int SCAN_CNT    = 50000,
    parameter int DEAD_CNT    = 500,
    parameter int BR_W        = 4,
    parameter int LZB_EN      = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int COL_ACT_LOW = 1
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               Enable,
    input  logic [4*N_DIG-1:0] Digit_Data,
    input  logic [N_DIG-1:0]   Dp_Mask,
    input  logic [N_DIG-1:0]   Blank_Mask,
    input  logic [BR_W-1:0]    Brightness,
    output logic [7:0]         Row_Scan_Sig,
    output logic [N_DIG-1:0]   Col_Scan_Sig,
    output logic               Frame_Sync
);

    localparam int SLOT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int DIG_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [SLOT_W-1:0]    r_slot_cnt;
    logic [DIG_W-1:0]     r_dig_idx;
    logic [BR_W-1:0]      r_pwm_cnt;
    logic [4*N_DIG-1:0]   r_snap_data;
    logic [N_DIG-1:0]     r_snap_dp;
    logic [N_DIG-1:0]     r_snap_blank;
    logic [7:0]           r_row;
    logic [N_DIG-1:0]     r_col;
    logic                 r_fs;

    logic                 w_take;
    logic                 w_slot_last;
    logic                 w_dig_last;
    logic [4*N_DIG-1:0]   w_data;
    logic [N_DIG-1:0]     w_dp;
    logic [N_DIG-1:0]     w_blank_mask;
    logic [N_DIG-1:0]     w_lz;
    logic [3:0]           w_nib;
    logic [6:0]           w_dec;
    logic                 w_blank;
    logic                 w_active;
    logic [7:0]           w_seg_on;
    logic [N_DIG-1:0]     w_onehot;
    logic [N_DIG-1:0]     w_col_raw;
    logic [N_DIG-1:0]     w_col_next;
    logic [N_DIG-1:0]     w_col_idle;
    logic [7:0]           w_row_next;
    logic [7:0]           w_row_idle;

    assign w_take      = Enable && (r_slot_cnt == '0) && (r_dig_idx == '0);
    assign w_slot_last = (r_slot_cnt == SLOT_W'(SCAN_CNT - 1));
    assign w_dig_last  = (r_dig_idx == DIG_W'(N_DIG - 1));

    // The snapshot cycle already displays from the freshly latched values
    assign w_data       = w_take ? Digit_Data : r_snap_data;
    assign w_dp         = w_take ? Dp_Mask    : r_snap_dp;
    assign w_blank_mask = w_take ? Blank_Mask : r_snap_blank;

    assign w_nib = w_data[4*int'(r_dig_idx) +: 4];

    smg_hex_decoder u_dec (
        .i_nibble (w_nib),
        .o_seg    (w_dec)
    );

    // Leading-zero flags: digit i is leading-zero when it and all higher nibbles are zero
    always_comb begin
        logic z;
        w_lz = '0;
        z    = 1'b1;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            z       = z & (w_data[4*i +: 4] == 4'd0);
            w_lz[i] = (LZB_EN != 0) && (i != 0) && z;
        end
    end

    assign w_blank  = w_blank_mask[r_dig_idx] | w_lz[r_dig_idx];
    assign w_active = Enable && (r_slot_cnt >= SLOT_W'(DEAD_CNT)) &&
                      (r_pwm_cnt < Brightness) && !w_blank;
    assign w_seg_on = {w_dp[r_dig_idx], w_dec};

    // One-hot digit select at the current scan index
    always_comb begin
        w_onehot            = '0;
        w_onehot[r_dig_idx] = 1'b1;
    end

    // Segments and selects go dark together so no digit ever shows a stale pattern
    assign w_col_raw  = w_active ? w_onehot : '0;
    assign w_col_next = (COL_ACT_LOW != 0) ? ~w_col_raw : w_col_raw;
    assign w_col_idle = (COL_ACT_LOW != 0) ? '1 : '0;
    assign w_row_next = apply_pol(w_active ? w_seg_on : 8'h00, SEG_ACT_LOW != 0);
    assign w_row_idle = apply_pol(8'h00, SEG_ACT_LOW != 0);

    // Slot, digit and PWM counters; all restart while disabled
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= '0;
            r_pwm_cnt  <= '0;
        end else if (!Enable) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_slot_last) begin
                r_slot_cnt <= '0;
                r_dig_idx  <= w_dig_last ? '0 : r_dig_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    // Frame snapshot of display inputs, taken at the start of the digit-0 slot
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_snap_data  <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
        end else if (!Enable) begin
            r_snap_data  <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
        end else if (w_take) begin
            r_snap_data  <= Digit_Data;
            r_snap_dp    <= Dp_Mask;
            r_snap_blank <= Blank_Mask;
        end
    end

    // Registered pin drivers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_row <= w_row_idle;
            r_col <= w_col_idle;
            r_fs  <= 1'b0;
        end else begin
            r_row <= w_row_next;
            r_col <= w_col_next;
            r_fs  <= w_take;
        end
    end

    assign Row_Scan_Sig = r_row;
    assign Col_Scan_Sig = r_col;
    assign Frame_Sync   = r_fs;

endmodule

// File: tb/tb_smg_scan_multi.sv
// Self-checking bench for smg_scan_multi (4 digits, 8-cycle slots, 2 dead cycles).
module tb_smg_scan_multi;

    localparam int N_DIG = 4;
    localparam int SCAN  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N_DIG * SCAN;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digit_data;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  brightness;
    logic [7:0]  row;
    logic [3:0]  col;
    logic        fsync;

    int checks   = 0;
    int failures = 0;

    // Reference model state: enabled-cycle count and the frame snapshot
    int          t;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic [7:0]  exp_row;
    logic [3:0]  exp_col;
    logic        exp_fs;
    int          exp_dig;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    smg_scan_multi #(
        .N_DIG(N_DIG), .SCAN_CNT(SCAN), .DEAD_CNT(DEAD), .BR_W(4),
        .LZB_EN(1), .SEG_ACT_LOW(1), .COL_ACT_LOW(1)
    ) dut (
        .CLK          (clk),
        .RSTn         (rst_n),
        .Enable       (en),
        .Digit_Data   (digit_data),
        .Dp_Mask      (dp_mask),
        .Blank_Mask   (blank_mask),
        .Brightness   (brightness),
        .Row_Scan_Sig (row),
        .Col_Scan_Sig (col),
        .Frame_Sync   (fsync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predict what the pins show after the coming edge, then advance one clock
    task automatic step();
        int dig, slot, pwm;
        logic [3:0] nib;
        logic blank_i, act;
        if (en && rst_n) begin
            if (t % FRAME == 0) begin
                m_data  = digit_data;
                m_dp    = dp_mask;
                m_blank = blank_mask;
            end
            dig  = (t / SCAN) % N_DIG;
            slot = t % SCAN;
            pwm  = t % 16;
            nib  = 4'((m_data >> (4 * dig)) & 16'hF);
            blank_i = m_blank[dig] || (dig != 0 && (m_data >> (4 * dig)) == 16'h0);
            act  = (slot >= DEAD) && (pwm < int'(brightness)) && !blank_i;
            exp_fs  = (t % FRAME == 0);
            exp_dig = dig;
            exp_row = act ? ~{m_dp[dig], seg_tab[nib]} : 8'hFF;
            exp_col = act ? ~(4'b0001 << dig) : 4'hF;
            t++;
        end else begin
            t = 0;
            m_data = '0; m_dp = '0; m_blank = '0;
            exp_fs = 1'b0; exp_dig = 0;
            exp_row = 8'hFF;
            exp_col = 4'hF;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        digit_data = 16'h1234; dp_mask = '0; blank_mask = '0; brightness = 4'd15;
        #12;
        checks += 3;
        if (row !== 8'hFF) begin failures++; $display("FAIL reset_row got=%h exp=ff", row); end
        if (col !== 4'hF)  begin failures++; $display("FAIL reset_col got=%h exp=f", col); end
        if (fsync !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", fsync); end
        @(negedge clk); rst_n = 1'b1; en = 1'b1; t = 0;
        for (int c = 0; c < 13; c++) step();
        #3 rst_n = 1'b0;
        #1;
        checks += 3;
        if (row !== 8'hFF) begin failures++; $display("FAIL midslot_reset_row got=%h exp=ff", row); end
        if (col !== 4'hF)  begin failures++; $display("FAIL midslot_reset_col got=%h exp=f", col); end
        if (fsync !== 1'b0) begin failures++; $display("FAIL midslot_reset_fs got=%b exp=0", fsync); end
        t = 0;
        @(negedge clk); rst_n = 1'b1;
        step();
        checks += 2;
        if (fsync !== 1'b1) begin failures++; $display("FAIL reset_first_fs got=%b exp=1", fsync); end
        if (col !== 4'hF) begin failures++; $display("FAIL reset_first_dead got=%h exp=f", col); end
        for (int c = 1; c < FRAME; c++) begin
            step();
            checks += 3;
            if (row !== exp_row) begin failures++; $display("FAIL reset_row t=%0d got=%h exp=%h", t, row, exp_row); end
            if (col !== exp_col) begin failures++; $display("FAIL reset_col t=%0d got=%h exp=%h", t, col, exp_col); end
            if (fsync !== exp_fs) begin failures++; $display("FAIL reset_fs t=%0d got=%b exp=%b", t, fsync, exp_fs); end
        end
    endtask

    task automatic test_basic();
        digit_data = 16'h1234; dp_mask = '0; blank_mask = '0; brightness = 4'd15;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            checks += 3;
            if (row !== exp_row) begin failures++; $display("FAIL basic_row t=%0d got=%h exp=%h", t, row, exp_row); end
            if (col !== exp_col) begin failures++; $display("FAIL basic_col t=%0d got=%h exp=%h", t, col, exp_col); end
            if (fsync !== exp_fs) begin failures++; $display("FAIL basic_fs t=%0d got=%b exp=%b", t, fsync, exp_fs); end
            if (col == 4'b1110) begin
                checks++;
                if (row !== ~8'h66) begin failures++; $display("FAIL basic_dig0 got=%h exp=%h", row, ~8'h66); end
            end
            if (col == 4'b0111) begin
                checks++;
                if (row !== ~8'h06) begin failures++; $display("FAIL basic_dig3 got=%h exp=%h", row, ~8'h06); end
            end
        end
    endtask

    task automatic test_lzb_dp();
        digit_data = 16'h0050; dp_mask = 4'b0010; blank_mask = '0; brightness = 4'd15;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            checks += 3;
            if (row !== exp_row) begin failures++; $display("FAIL lzb_row t=%0d got=%h exp=%h", t, row, exp_row); end
            if (col !== exp_col) begin failures++; $display("FAIL lzb_col t=%0d got=%h exp=%h", t, col, exp_col); end
            if (fsync !== exp_fs) begin failures++; $display("FAIL lzb_fs t=%0d got=%b exp=%b", t, fsync, exp_fs); end
            if (t > FRAME && (exp_dig == 2 || exp_dig == 3)) begin
                checks++;
                if (col !== 4'hF) begin failures++; $display("FAIL lzb_blank t=%0d got=%h exp=f", t, col); end
            end
            if (col == 4'b1101) begin
                checks++;
                if (row !== ~8'hED) begin failures++; $display("FAIL lzb_dp1 got=%h exp=%h", row, ~8'hED); end
            end
        end
    endtask

    task automatic test_snapshot();
        digit_data = 16'h1111; dp_mask = '0; blank_mask = '0; brightness = 4'd15;
        while (t % FRAME != 0) step();
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c == SCAN + 3) digit_data = 16'h2222;
            step();
            checks += 3;
            if (row !== exp_row) begin failures++; $display("FAIL snap_row t=%0d got=%h exp=%h", t, row, exp_row); end
            if (col !== exp_col) begin failures++; $display("FAIL snap_col t=%0d got=%h exp=%h", t, col, exp_col); end
            if (fsync !== exp_fs) begin failures++; $display("FAIL snap_fs t=%0d got=%b exp=%b", t, fsync, exp_fs); end
            if (c < FRAME && (col == 4'b1011 || col == 4'b0111)) begin
                checks++;
                if (row !== ~8'h06) begin failures++; $display("FAIL snap_old got=%h exp=%h", row, ~8'h06); end
            end
            if (c >= FRAME && col != 4'hF) begin
                checks++;
                if (row !== ~8'h5B) begin failures++; $display("FAIL snap_new got=%h exp=%h", row, ~8'h5B); end
            end
        end
    endtask

    task automatic test_brightness();
        int on_cnt, exp_on;
        digit_data = 16'h8888; dp_mask = 4'hF; blank_mask = '0; brightness = 4'd0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            checks++;
            if (col !== 4'hF) begin failures++; $display("FAIL bright0_col t=%0d got=%h exp=f", t, col); end
        end
        brightness = 4'd8;
        on_cnt = 0; exp_on = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (col != 4'hF) on_cnt++;
            if (exp_col != 4'hF) exp_on++;
            checks += 2;
            if (row !== exp_row) begin failures++; $display("FAIL bright8_row t=%0d got=%h exp=%h", t, row, exp_row); end
            if (col !== exp_col) begin failures++; $display("FAIL bright8_col t=%0d got=%h exp=%h", t, col, exp_col); end
        end
        checks++;
        if (on_cnt !== exp_on) begin failures++; $display("FAIL bright8_oncount got=%0d exp=%0d", on_cnt, exp_on); end
    endtask

    task automatic test_enable_drop();
        int guard;
        digit_data = 16'hABCD; dp_mask = 4'b0101; blank_mask = '0; brightness = 4'd15;
        guard = 0;
        while (!((t % FRAME) == 2 * SCAN + 4) && guard < 200) begin step(); guard++; end
        checks++;
        if (guard >= 200) begin failures++; $display("FAIL endrop_reach got=%0d exp=<200", guard); end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks += 3;
            if (row !== 8'hFF) begin failures++; $display("FAIL endrop_row got=%h exp=ff", row); end
            if (col !== 4'hF)  begin failures++; $display("FAIL endrop_col got=%h exp=f", col); end
            if (fsync !== 1'b0) begin failures++; $display("FAIL endrop_fs got=%b exp=0", fsync); end
        end
        en = 1'b1;
        step();
        checks++;
        if (fsync !== 1'b1) begin failures++; $display("FAIL reen_fs got=%b exp=1", fsync); end
        for (int c = 1; c < FRAME; c++) begin
            step();
            checks += 3;
            if (row !== exp_row) begin failures++; $display("FAIL reen_row t=%0d got=%h exp=%h", t, row, exp_row); end
            if (col !== exp_col) begin failures++; $display("FAIL reen_col t=%0d got=%h exp=%h", t, col, exp_col); end
            if (fsync !== exp_fs) begin failures++; $display("FAIL reen_fs t=%0d got=%b exp=%b", t, fsync, exp_fs); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 40 * FRAME; c++) begin
            if ($urandom_range(0, 9) == 0) digit_data = 16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF);
            if ($urandom_range(0, 19) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) blank_mask = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 199) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            step();
            checks += 3;
            if (row !== exp_row) begin failures++; $display("FAIL rand_row t=%0d got=%h exp=%h", t, row, exp_row); end
            if (col !== exp_col) begin failures++; $display("FAIL rand_col t=%0d got=%h exp=%h", t, col, exp_col); end
            if (fsync !== exp_fs) begin failures++; $display("FAIL rand_fs t=%0d got=%b exp=%b", t, fsync, exp_fs); end
        end
    endtask

    initial begin
        t = 0;
        m_data = '0; m_dp = '0; m_blank = '0;
        test_reset();
        test_basic();
        test_lzb_dp();
        test_snapshot();
        test_brightness();
        test_enable_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
